// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timer: FSM states, register offsets,
// MODE values and the bus addresses of the two timer instances.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // Byte addresses shared with the store checker.
  localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] T0_COUNT = 32'h0000_7F08;
  localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] T1_COUNT = 32'h0000_7F18;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with one-shot or periodic interrupt; CTRL/PRESET writable, COUNT read-only.
// Sees only legal word accesses already range-checked by the bridge.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CTRL_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             IRQ
);

  state_e                 r_state, w_state_d;
  logic [CTRL_BITS-1:0]   r_ctrl, w_ctrl_d;
  logic [WIDTH-1:0]       r_preset, w_preset_d;
  logic [WIDTH-1:0]       r_count, w_count_d;
  logic                   r_irq_flag, w_irq_flag_d;

  logic [1:0]             w_off;
  logic                   w_wr_ctrl;
  logic                   w_wr_preset;
  logic                   w_en;
  logic                   w_periodic;
  logic                   w_unused_addr;

  assign w_off         = Addr[3:2];
  assign w_unused_addr = ^Addr[31:4];
  assign w_wr_ctrl     = WE && (w_off == OFF_CTRL);
  assign w_wr_preset   = WE && (w_off == OFF_PRESET);
  assign w_en          = r_ctrl[0];
  assign w_periodic    = (r_ctrl[2:1] == MODE_PERIODIC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ctrl     <= w_ctrl_d;
      r_preset   <= w_preset_d;
      r_count    <= w_count_d;
      r_irq_flag <= w_irq_flag_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_ctrl_d     = r_ctrl;
    w_preset_d   = r_preset;
    w_count_d    = r_count;
    w_irq_flag_d = r_irq_flag;

    // CPU writes are applied first so that FSM set/clear below can take precedence where needed.
    if (w_wr_ctrl || w_wr_preset) begin
      w_irq_flag_d = 1'b0;
    end
    if (w_wr_preset) begin
      w_preset_d = Din;
    end

    unique case (r_state)
      StIdle: begin
        if (w_en) begin
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_count_d = r_preset;
        w_state_d = StCnt;
      end
      StCnt: begin
        if (!w_en) begin
          w_state_d = StIdle;
        end else if (r_count > WIDTH'(1)) begin
          w_count_d = r_count - WIDTH'(1);
        end else begin
          w_count_d    = '0;
          w_irq_flag_d = 1'b1;
          w_state_d    = StInt;
        end
      end
      StInt: begin
        if (w_periodic) begin
          w_irq_flag_d = 1'b0;
        end else begin
          w_ctrl_d[0] = 1'b0;
        end
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // A CTRL write in the INT cycle overrides the one-shot EN clear.
    if (w_wr_ctrl) begin
      w_ctrl_d = Din[CTRL_BITS-1:0];
    end
  end

  always_comb begin
    Dout = '0;
    unique case (w_off)
      OFF_CTRL:   Dout = {{(WIDTH-CTRL_BITS){1'b0}}, r_ctrl};
      OFF_PRESET: Dout = r_preset;
      OFF_COUNT:  Dout = r_count;
      OFF_RSVD:   Dout = '0;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset, one-shot, periodic, masked,
// disable mid-count, ignored writes and the INT-cycle CTRL write collision.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_asserts;
  int n_fail;

  timer_counter #(.WIDTH(32), .CTRL_BITS(4)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
    Addr = {28'd0, off};
    #1;
    chk(tag, Dout, exp);
  endtask

  // Drives a one-cycle write; returns just after the edge that captured it.
  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    Addr = {28'd0, off};
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    Addr      = '0;
    WE        = 1'b0;
    Din       = '0;
    reset     = 1'b0;

    // Reset state
    do_reset();
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(StIdle));
    chk_reg("rst_ctrl", OFF_CTRL, 32'd0);
    chk_reg("rst_preset", OFF_PRESET, 32'd0);
    chk_reg("rst_count", OFF_COUNT, 32'd0);

    // 1: reset asserted mid-count, between edges
    wr(OFF_PRESET, 32'd5);
    wr(OFF_CTRL, 32'h9);
    tick();
    tick();
    chk_reg("t1_count5", OFF_COUNT, 32'd5);
    chk("t1_state_cnt", 32'(dut.r_state), 32'(StCnt));
    #1;
    reset = 1'b1;
    #1;
    chk("t1_irq", 32'(IRQ), 32'd0);
    chk("t1_state_idle", 32'(dut.r_state), 32'(StIdle));
    chk_reg("t1_count0", OFF_COUNT, 32'd0);
    tick();
    reset = 1'b0;

    // 2: one-shot, PRESET=3
    wr(OFF_PRESET, 32'd3);
    wr(OFF_CTRL, 32'h9);                    // edge 0
    tick();                                 // edge 1
    chk("t2_state_load", 32'(dut.r_state), 32'(StLoad));
    for (int e = 2; e <= 5; e++) begin
      tick();
      chk_reg($sformatf("t2_count_e%0d", e), OFF_COUNT, 32'(5 - e));
      chk($sformatf("t2_irq_e%0d", e), 32'(IRQ), (e == 5) ? 32'd1 : 32'd0);
    end
    tick();                                 // edge 6
    chk_reg("t2_ctrl_en_clr", OFF_CTRL, 32'h8);
    chk("t2_irq_e6", 32'(IRQ), 32'd1);
    tick();
    tick();
    chk("t2_irq_hold", 32'(IRQ), 32'd1);
    chk("t2_state_idle", 32'(dut.r_state), 32'(StIdle));
    wr(OFF_CTRL, 32'h8);
    chk("t2_irq_cleared", 32'(IRQ), 32'd0);

    // 3: periodic, PRESET=2, 5-cycle period
    do_reset();
    wr(OFF_PRESET, 32'd2);
    wr(OFF_CTRL, 32'hB);                    // edge 0
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("t3_irq_e%0d", e), 32'(IRQ),
          (e >= 4 && ((e - 4) % 5) == 0) ? 32'd1 : 32'd0);
      if (e == 2 || e == 7 || e == 12) chk_reg($sformatf("t3_reload_e%0d", e), OFF_COUNT, 32'd2);
      if (e == 4 || e == 9 || e == 14) chk_reg($sformatf("t3_zero_e%0d", e), OFF_COUNT, 32'd0);
    end
    chk_reg("t3_ctrl_kept", OFF_CTRL, 32'hB);

    // 4: masked one-shot
    do_reset();
    wr(OFF_PRESET, 32'd3);
    wr(OFF_CTRL, 32'h1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t4_irq_e%0d", e), 32'(IRQ), 32'd0);
      if (e == 5) chk_reg("t4_count0", OFF_COUNT, 32'd0);
    end
    chk_reg("t4_en_clr", OFF_CTRL, 32'h0);
    chk("t4_flag_set", 32'(dut.r_irq_flag), 32'd1);

    // 5: disable mid-count, PRESET=10
    do_reset();
    wr(OFF_PRESET, 32'd10);
    wr(OFF_CTRL, 32'h9);                    // edge 0
    for (int e = 1; e <= 5; e++) tick();
    chk_reg("t5_count7", OFF_COUNT, 32'd7);
    wr(OFF_CTRL, 32'h0);                    // edge 6
    chk_reg("t5_count6", OFF_COUNT, 32'd6);
    for (int e = 7; e <= 10; e++) begin
      tick();
      chk($sformatf("t5_irq_e%0d", e), 32'(IRQ), 32'd0);
    end
    chk_reg("t5_frozen", OFF_COUNT, 32'd6);
    chk("t5_state_idle", 32'(dut.r_state), 32'(StIdle));

    // 6a: ignored writes to COUNT and reserved offsets
    wr(OFF_COUNT, 32'd7);
    chk_reg("t6_count_ign", OFF_COUNT, 32'd6);
    wr(OFF_RSVD, 32'hFFFF_FFFF);
    chk_reg("t6_rsvd_zero", OFF_RSVD, 32'd0);
    chk_reg("t6_ctrl_keep", OFF_CTRL, 32'h0);
    chk_reg("t6_preset_keep", OFF_PRESET, 32'd10);

    // 5b: re-enable reloads PRESET
    wr(OFF_CTRL, 32'h9);
    tick();
    tick();
    chk_reg("t5_reload", OFF_COUNT, 32'd10);

    // 6b: CTRL write in the INT cycle of a one-shot, PRESET=1
    do_reset();
    wr(OFF_PRESET, 32'd1);
    wr(OFF_CTRL, 32'h9);                    // edge 0
    tick();                                 // edge 1: LOAD
    tick();                                 // edge 2: COUNT=1
    tick();                                 // edge 3: INT
    chk("t6_state_int", 32'(dut.r_state), 32'(StInt));
    chk("t6_irq_int", 32'(IRQ), 32'd1);
    wr(OFF_CTRL, 32'h9);                    // edge 4
    chk_reg("t6_en_wins", OFF_CTRL, 32'h9);
    chk("t6_irq_clr", 32'(IRQ), 32'd0);
    tick();                                 // edge 5
    chk("t6_restart_load", 32'(dut.r_state), 32'(StLoad));
    tick();                                 // edge 6
    chk_reg("t6_restart_cnt", OFF_COUNT, 32'd1);
    tick();                                 // edge 7
    chk("t6_irq_again", 32'(IRQ), 32'd1);

    // PRESET=0 still reaches INT on the first CNT edge
    do_reset();
    wr(OFF_CTRL, 32'h9);
    tick();
    tick();
    tick();
    chk("p0_irq", 32'(IRQ), 32'd1);
    chk_reg("p0_count", OFF_COUNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
